bpred_gshare_btb: RTL
=====================

// Module: bpred_gshare_btb
// PURPOSE
// - Parametrised successor to the core's single-counter branch predictor: PC/history-indexed pattern history table (PHT) of saturating counters plus a direct-mapped branch target buffer (BTB).
// - Prediction lookup is combinational from the IF-stage PC and feeds the nextPC mux and IF_ID (pred_taken, pred_idx).
// - Update is taken from the ID-stage branch resolution (branchALU result and BranchAdder target). Global history is updated non-speculatively, at resolution only.
// PARAMETERS
// - PHT_ENTRIES  64  counter count; power of 2, >=4; IDX_W = log2(PHT_ENTRIES).
// - CNTR_BITS    2   saturating counter width, 1..4.
// - GHR_BITS     6   global history length, 0..IDX_W; 0 forces bimodal.
// - BTB_ENTRIES  16  direct-mapped BTB size; power of 2; BIDX_W = log2(BTB_ENTRIES).
// - MODE         1   0 = bimodal (index = pc bits only), 1 = gshare (index = pc bits XOR ghr).
// PORTS
// - clk              in   1      core clock, rising edge.
// - reset_n          in   1      asynchronous, active-low reset.
// - if_pc            in   32     PC being fetched.
// - pred_taken       out  1      predict taken (counter MSB=1 AND BTB hit).
// - pred_target      out  32     BTB target if pred_taken, else if_pc+4.
// - pred_idx         out  IDX_W  PHT index used; piped through IF_ID and returned as upd_idx.
// - upd_valid        in   1      ID holds a resolved conditional branch this cycle (ID_cntl_Branch qualified by IF_IDWrite).
// - upd_pc           in   32     PC of the resolving branch (ID_PC).
// - upd_idx          in   IDX_W  pred_idx that was captured with that branch.
// - upd_taken        in   1      actual outcome (ID_ExeBranch).
// - upd_target       in   32     actual taken target (ID_BranchAddr).
// - upd_mispredict   in   1      direction or target mispredicted; statistics only.
// - stat_branches    out  32     count of upd_valid cycles.
// - stat_mispredicts out  32     count of upd_valid&&upd_mispredict cycles.
// BEHAVIOUR
// - Reset:
//   - all counters = weakly-not-taken (2^(CNTR_BITS-1)-1; 1-bit counter = 0).
//   - BTB valid bits = 0; ghr = 0; both stats = 0.
//   - Outputs therefore reset to pred_taken=0, pred_target=if_pc+4.
//   - Reset asserted mid-operation discards all state, including an update in the same cycle.
// - Lookup:
//   - Zero-cycle latency, purely combinational on if_pc and registered state.
//   - pred_idx = if_pc[IDX_W+1:2] ^ (MODE ? {zeros, ghr} : 0).
//   - BTB: bidx = if_pc[BIDX_W+1:2]; tag = if_pc[31:BIDX_W+2]; hit = valid[bidx] && tag match.
// - Update (rising edge, only when upd_valid=1):
//   - Counter at upd_idx: +1 if taken, -1 if not; saturates at 0 and at 2^CNTR_BITS-1, with no wrap.
//   - ghr <= {ghr[GHR_BITS-2:0], upd_taken}; ghr is unused when GHR_BITS=0.
//   - Taken: BTB[upd_pc bidx] <= {valid=1, tag, upd_target}, overwriting any alias.
//   - Not taken: BTB unchanged.
//   - Stats increment and wrap modulo 2^32.
// - Simultaneous lookup and update of the same entry: lookup returns the pre-update value (read-old). No bypass.
// - upd_valid=0: no state changes, including while the pipeline is stalled.
// - Jumps (JAL/JALR) are not presented; the nextPC mux keeps them at higher priority.
// - The block never stalls and has no handshake beyond upd_valid.
// STRUCTURE
// - Shared package/header: mode constants BP_MODE_BIMODAL=0 and BP_MODE_GSHARE=1; counter-update function sat_cnt_next(cnt, taken).
// - Sub-module bp_btb_dm: direct-mapped BTB, arrays plus tag compare; parameters BTB_ENTRIES.
// - PHT, ghr and stats stay in this module, as flops with per-entry async reset, not RAM, so reset is single-cycle.
// TESTING
// - After reset, any if_pc (e.g. 0x100) -> pred_taken=0, pred_target=0x104, stats=0.
// - MODE=0: taken update at pc 0x40 target 0x80, twice -> lookup 0x40 gives pred_taken=1, target 0x80. 3 not-taken updates -> pred_taken=0, counter saturates at 0.
// - Saturation: 5 taken updates then 1 not-taken -> still predicts taken (3->2). Counter never exceeds 3.
// - MODE=1, GHR_BITS=2: alternating T/N branch at 0x200 for 20 updates -> after warm-up, mispredicts stop. stat_branches=20; stat_mispredicts matches the bench model.
// - BTB alias: pc 0x40 and 0x80 (BTB_ENTRIES=16), both taken -> 0x40 misses (pred_taken=0) until retrained. Same-edge update and lookup of one entry returns the old value.
// - reset_n dropped asynchronously mid-stream with upd_valid=1 -> state returns to reset values immediately; update is lost.

Source files
------------

// File: rtl/bpred_gshare_btb_pkg.sv
// Shared constants and helpers for the gshare/bimodal branch predictor.
package bpred_gshare_btb_pkg;

  localparam int BP_MODE_BIMODAL = 0;
  localparam int BP_MODE_GSHARE  = 1;
  localparam int BP_PC_W         = 32;

  // Saturating up/down counter step; counters up to 4 bits wide.
  function automatic logic [3:0] sat_cnt_next(input logic [3:0] cnt,
                                              input logic       taken,
                                              input logic [3:0] cnt_max);
    logic [3:0] nxt;
    if (taken) begin
      if (cnt >= cnt_max) nxt = cnt;
      else                nxt = cnt + 4'd1;
    end else begin
      if (cnt == 4'd0)    nxt = cnt;
      else                nxt = cnt - 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpred_gshare_btb_if.sv
// Lookup/update/statistics bundle between the core pipeline and the predictor.
interface bpred_gshare_btb_if #(
  parameter int IDX_W = 6
) ();
  import bpred_gshare_btb_pkg::*;

  logic [BP_PC_W-1:0] if_pc;
  logic               pred_taken;
  logic [BP_PC_W-1:0] pred_target;
  logic [IDX_W-1:0]   pred_idx;
  logic               upd_valid;
  logic [BP_PC_W-1:0] upd_pc;
  logic [IDX_W-1:0]   upd_idx;
  logic               upd_taken;
  logic [BP_PC_W-1:0] upd_target;
  logic               upd_mispredict;
  logic [31:0]        stat_branches;
  logic [31:0]        stat_mispredicts;

  // Core pipeline side.
  modport master (
    output if_pc, upd_valid, upd_pc, upd_idx, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target, pred_idx, stat_branches, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_idx, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target, pred_idx, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bpred_gshare_btb_btb.sv
// Direct-mapped branch target buffer: valid/tag/target per slot, combinational lookup.
module bp_btb_dm
  import bpred_gshare_btb_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BP_PC_W-1:0] i_lkp_pc,
  output logic               o_hit,
  output logic [BP_PC_W-1:0] o_target,
  input  logic               i_wr_en,
  input  logic [BP_PC_W-1:0] i_wr_pc,
  input  logic [BP_PC_W-1:0] i_wr_target
);
  localparam int BIDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = BP_PC_W - BIDX_W - 2;

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
  logic [BP_PC_W-1:0]     r_tgt [BTB_ENTRIES];

  logic [BIDX_W-1:0] w_lkp_bidx;
  logic [BIDX_W-1:0] w_wr_bidx;
  logic [TAG_W-1:0]  w_lkp_tag;
  logic [TAG_W-1:0]  w_wr_tag;
  logic              w_unused_pc_bits;

  assign w_lkp_bidx       = i_lkp_pc[BIDX_W+1:2];
  assign w_lkp_tag        = i_lkp_pc[BP_PC_W-1:BIDX_W+2];
  assign w_wr_bidx        = i_wr_pc[BIDX_W+1:2];
  assign w_wr_tag         = i_wr_pc[BP_PC_W-1:BIDX_W+2];
  assign w_unused_pc_bits = ^{i_lkp_pc[1:0], i_wr_pc[1:0]};

  // Taken branch claims its slot, evicting whichever alias was there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_valid[w_wr_bidx] <= 1'b1;
      r_tag[w_wr_bidx]   <= w_wr_tag;
      r_tgt[w_wr_bidx]   <= i_wr_target;
    end
  end

  // Lookup reads the current (pre-write) contents; there is no write bypass.
  assign o_hit    = r_valid[w_lkp_bidx] && (r_tag[w_lkp_bidx] == w_lkp_tag);
  assign o_target = r_tgt[w_lkp_bidx];

endmodule

// File: rtl/bpred_gshare_btb.sv
// Gshare/bimodal direction predictor with a direct-mapped BTB and resolution statistics.
module bpred_gshare_btb
  import bpred_gshare_btb_pkg::*;
#(
  parameter int PHT_ENTRIES = 64,
  parameter int CNTR_BITS   = 2,
  parameter int GHR_BITS    = 6,
  parameter int BTB_ENTRIES = 16,
  parameter int MODE        = BP_MODE_GSHARE
) (
  input  logic                clk,
  input  logic                reset_n,
  bpred_gshare_btb_if.slave   bp
);
  localparam int IDX_W = $clog2(PHT_ENTRIES);
  localparam int GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;
  // Weakly-not-taken; evaluates to 0 for a 1-bit counter.
  localparam logic [CNTR_BITS-1:0] CNT_RST = CNTR_BITS'((1 << (CNTR_BITS - 1)) - 1);
  localparam logic [3:0]           CNT_MAX = 4'((1 << CNTR_BITS) - 1);

  logic [CNTR_BITS-1:0] r_pht [PHT_ENTRIES];
  logic [GHR_W-1:0]     r_ghr;
  logic [31:0]          r_stat_br;
  logic [31:0]          r_stat_mp;

  logic [IDX_W-1:0]     w_hist;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_dir_taken;
  logic                 w_btb_hit;
  logic [BP_PC_W-1:0]   w_btb_tgt;
  logic [CNTR_BITS-1:0] w_cnt_next;

  // History contribution to the index; zero in bimodal mode or with no history.
  always_comb begin
    w_hist = '0;
    if (MODE == BP_MODE_GSHARE && GHR_BITS > 0) begin
      w_hist = IDX_W'(r_ghr);
    end else begin
      w_hist = '0;
    end
  end

  assign w_idx       = bp.if_pc[IDX_W+1:2] ^ w_hist;
  assign w_dir_taken = r_pht[w_idx][CNTR_BITS-1];
  assign bp.pred_idx = w_idx;

  // Redirect only when direction says taken and a target is known.
  always_comb begin
    bp.pred_taken  = 1'b0;
    bp.pred_target = bp.if_pc + 32'd4;
    if (w_dir_taken && w_btb_hit) begin
      bp.pred_taken  = 1'b1;
      bp.pred_target = w_btb_tgt;
    end else begin
      bp.pred_taken  = 1'b0;
      bp.pred_target = bp.if_pc + 32'd4;
    end
  end

  assign w_cnt_next = CNTR_BITS'(sat_cnt_next(4'(r_pht[bp.upd_idx]), bp.upd_taken, CNT_MAX));

  // PHT held in flops so every counter returns to weakly-not-taken in one reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        r_pht[i] <= CNT_RST;
      end
    end else if (bp.upd_valid) begin
      r_pht[bp.upd_idx] <= w_cnt_next;
    end
  end

  // Non-speculative global history: shifted only by resolved branches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ghr <= '0;
    end else if (bp.upd_valid && GHR_BITS > 0) begin
      r_ghr <= GHR_W'({r_ghr, bp.upd_taken});
    end
  end

  // Free-running resolution statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_br <= 32'd0;
      r_stat_mp <= 32'd0;
    end else if (bp.upd_valid) begin
      r_stat_br <= r_stat_br + 32'd1;
      if (bp.upd_mispredict) begin
        r_stat_mp <= r_stat_mp + 32'd1;
      end
    end
  end

  assign bp.stat_branches    = r_stat_br;
  assign bp.stat_mispredicts = r_stat_mp;

  bp_btb_dm #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_lkp_pc    (bp.if_pc),
    .o_hit       (w_btb_hit),
    .o_target    (w_btb_tgt),
    .i_wr_en     (bp.upd_valid && bp.upd_taken),
    .i_wr_pc     (bp.upd_pc),
    .i_wr_target (bp.upd_target)
  );

endmodule
